// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extension, result select
// and the retired-instruction counter.
module wb_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            m_valid,
    input  logic [XLEN-1:0] m_alu_data,
    input  logic [XLEN-1:0] m_ld_data,
    input  logic [XLEN-1:0] m_pc_four,
    input  logic [XLEN-1:0] m_imm,
    input  logic [1:0]      m_wb_sel,
    input  logic [2:0]      m_ld_f3,
    input  logic [1:0]      m_addr_lo,
    input  logic [RA_W-1:0] m_rd,
    input  logic            m_rd_wren,
    output logic [XLEN-1:0] wb_data,
    output logic [RA_W-1:0] wb_rd,
    output logic            wb_rd_wren,
    output logic            wb_valid,
    output logic [63:0]     instret
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] ld;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
        logic [1:0]      sel;
        logic [2:0]      f3;
        logic [1:0]      lo;
        logic [RA_W-1:0] rd;
        logic            wren;
    } mw_t;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_LD  = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    mw_t r;
    mw_t r_in;

    logic            retire;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_w;
    logic [XLEN-1:0] ld_ext;

    assign r_in = '{
        valid: m_valid,
        alu:   m_alu_data,
        ld:    m_ld_data,
        pc4:   m_pc_four,
        imm:   m_imm,
        sel:   m_wb_sel,
        f3:    m_ld_f3,
        lo:    m_addr_lo,
        rd:    m_rd,
        wren:  m_rd_wren
    };

    // Flush wins over stall: the bubble replaces even a held entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (flush) begin
            r <= '0;
        end else if (!stall) begin
            r <= r_in;
        end
    end

    // A valid entry retires when it leaves the register, whether it is
    // replaced by the next instruction or displaced by a flush bubble.
    assign retire = r.valid && (!stall || flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end

    always_comb begin
        ld_w = r.ld[31:0];
        ld_h = r.lo[1] ? ld_w[31:16] : ld_w[15:0];
        ld_b = 8'h00;
        unique case (r.lo)
            2'd0: ld_b = ld_w[7:0];
            2'd1: ld_b = ld_w[15:8];
            2'd2: ld_b = ld_w[23:16];
            2'd3: ld_b = ld_w[31:24];
            default: ld_b = 8'h00;
        endcase
    end

    always_comb begin
        ld_ext = r.ld;
        unique case (r.f3)
            F3_LB:   ld_ext = XLEN'($signed(ld_b));
            F3_LBU:  ld_ext = XLEN'(ld_b);
            F3_LH:   ld_ext = XLEN'($signed(ld_h));
            F3_LHU:  ld_ext = XLEN'(ld_h);
            F3_LW:   ld_ext = XLEN'($signed(ld_w));
            default: ld_ext = r.ld;
        endcase
    end

    always_comb begin
        wb_data = '0;
        if (r.valid) begin
            unique case (r.sel)
                SEL_ALU: wb_data = r.alu;
                SEL_LD:  wb_data = ld_ext;
                SEL_PC4: wb_data = r.pc4;
                SEL_IMM: wb_data = r.imm;
                default: wb_data = '0;
            endcase
        end
    end

    assign wb_valid   = r.valid;
    assign wb_rd      = r.rd;
    assign wb_rd_wren = r.valid && r.wren && (r.rd != '0);

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed scoreboard bench for wb_stage against an
// instruction-level reference model.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        m_valid;
    logic [31:0] m_alu_data;
    logic [31:0] m_ld_data;
    logic [31:0] m_pc_four;
    logic [31:0] m_imm;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_ld_f3;
    logic [1:0]  m_addr_lo;
    logic [4:0]  m_rd;
    logic        m_rd_wren;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rd_wren;
    logic        wb_valid;
    logic [63:0] instret;

    wb_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_alu_data (m_alu_data),
        .m_ld_data  (m_ld_data),
        .m_pc_four  (m_pc_four),
        .m_imm      (m_imm),
        .m_wb_sel   (m_wb_sel),
        .m_ld_f3    (m_ld_f3),
        .m_addr_lo  (m_addr_lo),
        .m_rd       (m_rd),
        .m_rd_wren  (m_rd_wren),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_rd_wren (wb_rd_wren),
        .wb_valid   (wb_valid),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit        rst;
        bit        stall;
        bit        flush;
        bit        v;
        bit [31:0] alu;
        bit [31:0] ld;
        bit [31:0] pc4;
        bit [31:0] imm;
        bit [1:0]  sel;
        bit [2:0]  f3;
        bit [1:0]  lo;
        bit [4:0]  rd;
        bit        wren;
    } in_t;

    typedef struct packed {
        bit        v;
        bit [31:0] data;
        bit [4:0]  rd;
        bit        wren;
        bit [63:0] ir;
    } exp_t;

    exp_t        sb[$];
    in_t         held;
    longint unsigned model_ir;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Load result from the ISA definition of each load width.
    function automatic bit [31:0] load_val(input bit [31:0] w,
                                           input bit [2:0] f3,
                                           input bit [1:0] off);
        longint b;
        longint h;
        b = (longint'(w) >> (8 * off)) % 256;
        h = (longint'(w) >> (16 * (off / 2))) % 65536;
        case (f3)
            3'b000:  return 32'(b >= 128 ? b - 256 : b);
            3'b100:  return 32'(b);
            3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic exp_t expect_of(input in_t e, input longint unsigned ir);
        exp_t x;
        bit [31:0] srcs[4];
        srcs[0] = e.alu;
        srcs[1] = load_val(e.ld, e.f3, e.lo);
        srcs[2] = e.pc4;
        srcs[3] = e.imm;
        x.v    = e.v;
        x.data = e.v ? srcs[e.sel] : 32'h0;
        x.rd   = e.rd;
        x.wren = e.v && e.wren && (e.rd != 0);
        x.ir   = ir;
        return x;
    endfunction

    // One clock edge of the instruction-level model.
    task automatic model_edge(input in_t x);
        if (x.rst) begin
            held     = '0;
            model_ir = 0;
        end else begin
            if (held.v && (!x.stall || x.flush)) model_ir = model_ir + 1;
            if (x.flush) held.v = 1'b0;
            else if (!x.stall) held = x;
        end
        sb.push_back(expect_of(held, model_ir));
    endtask

    task automatic drive(input in_t x, input bit pulse);
        @(negedge clk);
        if (pulse) begin
            #1 rst = 1'b1;
            #1;
            chk("rstpulse_valid", 64'(wb_valid), 64'd0);
            chk("rstpulse_data", 64'(wb_data), 64'd0);
            chk("rstpulse_rd", 64'(wb_rd), 64'd0);
            chk("rstpulse_wren", 64'(wb_rd_wren), 64'd0);
            chk("rstpulse_instret", instret, 64'd0);
            rst      = 1'b0;
            held     = '0;
            model_ir = 0;
        end
        rst        = x.rst;
        stall      = x.stall;
        flush      = x.flush;
        m_valid    = x.v;
        m_alu_data = x.alu;
        m_ld_data  = x.ld;
        m_pc_four  = x.pc4;
        m_imm      = x.imm;
        m_wb_sel   = x.sel;
        m_ld_f3    = x.f3;
        m_addr_lo  = x.lo;
        m_rd       = x.rd;
        m_rd_wren  = x.wren;
        model_edge(x);
    endtask

    task automatic const_chk(input string name, input logic [31:0] exp);
        @(posedge clk);
        #2 chk(name, 64'(wb_data), 64'(exp));
    endtask

    function automatic in_t instr(input bit [1:0] sel, input bit [31:0] val,
                                  input bit [4:0] rd);
        in_t x;
        x      = '0;
        x.v    = 1'b1;
        x.sel  = sel;
        x.alu  = val;
        x.imm  = val;
        x.pc4  = val;
        x.rd   = rd;
        x.wren = 1'b1;
        return x;
    endfunction

    function automatic in_t ld_instr(input bit [2:0] f3, input bit [1:0] lo);
        in_t x;
        x     = instr(2'b01, 32'h0, 5'd7);
        x.ld  = 32'h80FF7F01;
        x.f3  = f3;
        x.lo  = lo;
        return x;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.rst   = ($urandom_range(0, 99) == 0);
        x.stall = ($urandom_range(0, 4) == 0);
        x.flush = ($urandom_range(0, 9) == 0);
        x.v     = ($urandom_range(0, 3) != 0);
        x.alu   = $urandom;
        x.ld    = $urandom;
        x.pc4   = $urandom;
        x.imm   = $urandom;
        x.sel   = 2'($urandom);
        x.f3    = 3'($urandom);
        x.lo    = 2'($urandom);
        x.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        x.wren  = 1'($urandom);
        return x;
    endfunction

    // Monitor: every post-edge output is compared with the model's entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("valid", 64'(wb_valid), 64'(e.v));
                chk("data", 64'(wb_data), 64'(e.data));
                chk("rd_wren", 64'(wb_rd_wren), 64'(e.wren));
                chk("instret", instret, e.ir);
                if (e.v) chk("rd", 64'(wb_rd), 64'(e.rd));
            end
        end
    end

    initial begin
        in_t x;
        in_t idle;
        idle       = '0;
        held       = '0;
        model_ir   = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        m_valid    = 1'b0;
        m_alu_data = '0;
        m_ld_data  = '0;
        m_pc_four  = '0;
        m_imm      = '0;
        m_wb_sel   = '0;
        m_ld_f3    = '0;
        m_addr_lo  = '0;
        m_rd       = '0;
        m_rd_wren  = 1'b0;

        x = idle;
        x.rst = 1'b1;
        drive(x, 1'b0);
        drive(x, 1'b0);

        drive(instr(2'b00, 32'h1234, 5'd1), 1'b0);
        const_chk("sel_alu", 32'h1234);
        drive(instr(2'b11, 32'hABCD0000, 5'd2), 1'b0);
        const_chk("sel_imm", 32'hABCD0000);
        drive(instr(2'b10, 32'h0000_1008, 5'd3), 1'b0);
        const_chk("sel_pc4", 32'h0000_1008);

        drive(ld_instr(3'b000, 2'd3), 1'b0);
        const_chk("lb_off3", 32'hFFFFFF80);
        drive(ld_instr(3'b100, 2'd1), 1'b0);
        const_chk("lbu_off1", 32'h0000007F);
        drive(ld_instr(3'b001, 2'd2), 1'b0);
        const_chk("lh_off2", 32'hFFFF80FF);
        drive(ld_instr(3'b101, 2'd0), 1'b0);
        const_chk("lhu_off0", 32'h00007F01);
        drive(ld_instr(3'b010, 2'd3), 1'b0);
        const_chk("lw", 32'h80FF7F01);

        drive(instr(2'b00, 32'hCAFE0001, 5'd9), 1'b0);
        for (int i = 0; i < 3; i++) begin
            x = instr(2'b00, 32'h1111_0000 + i, 5'd4);
            x.stall = 1'b1;
            drive(x, 1'b0);
            const_chk("stall_hold", 32'hCAFE0001);
        end
        drive(idle, 1'b0);
        const_chk("stall_release", 32'h0);

        drive(instr(2'b00, 32'h77, 5'd5), 1'b0);
        x = instr(2'b00, 32'h88, 5'd6);
        x.stall = 1'b1;
        x.flush = 1'b1;
        drive(x, 1'b0);
        const_chk("flush_data", 32'h0);

        drive(instr(2'b00, 32'h55, 5'd0), 1'b0);
        const_chk("x0_data", 32'h55);
        chk("x0_wren", 64'(wb_rd_wren), 64'd0);

        drive(instr(2'b00, 32'h99, 5'd8), 1'b0);
        drive(instr(2'b11, 32'h1000, 5'd10), 1'b1);

        for (int i = 0; i < 400; i++) begin
            drive(rand_in(), ($urandom_range(0, 49) == 0));
        end
        drive(idle, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
